// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the writeback arbiter.
// Optional feature macro: WB_BYPASS_EN (enables the decode bypass lookup).
package wb_arbiter_pkg;

    localparam int WB_WIDTH   = 32;
    localparam int WB_R_WIDTH = 5;
    localparam int WB_DEPTH   = 4;

    // Which element of the pending set loads the output register this cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_QUEUE,
        SRC_PIPE,
        SRC_MC
    } wb_src_e;

    // Width needed to hold an occupancy of 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Ordered pending-write queue: entry 0 is always the oldest.
// Accepts up to two pushes (a before b) and one pop per cycle; the pop
// is applied first so pushes land behind the surviving entries.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int EW    = 37,
    parameter int DEPTH = 4,
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       pop,
    input  logic                       push_a,
    input  logic [EW-1:0]              data_a,
    input  logic                       push_b,
    input  logic [EW-1:0]              data_b,
    output logic [CW-1:0]              count,
    output logic [DEPTH-1:0]           valid,
    output logic [DEPTH-1:0][EW-1:0]   entries
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][EW-1:0] mem, mem_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;

    // Next queue contents: shift out the head, then append pushes in order.
    always_comb begin
        mem_nxt = mem;
        cnt_nxt = cnt;
        if (pop && cnt != '0) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_nxt[i] = mem[i+1];
            mem_nxt[DEPTH-1] = '0;
            cnt_nxt = cnt - CW'(1);
        end
        if (push_a && cnt_nxt < CW'(DEPTH)) begin
            mem_nxt[cnt_nxt[IW-1:0]] = data_a;
            cnt_nxt = cnt_nxt + CW'(1);
        end
        if (push_b && cnt_nxt < CW'(DEPTH)) begin
            mem_nxt[cnt_nxt[IW-1:0]] = data_b;
            cnt_nxt = cnt_nxt + CW'(1);
        end
    end

    // Queue state; reset drops everything pending.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem <= '0;
            cnt <= '0;
        end else begin
            mem <= mem_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Occupancy as per-entry valid bits for the bypass search.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) valid[i] = CW'(i) < cnt;
    end

    assign count   = cnt;
    assign entries = mem;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline and multicycle results onto the single
// regfile write port through an ordered pending queue; r0 writes are dropped.
// Optional feature macro: WB_BYPASS_EN (bypass lookup for decode forwarding).
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int WIDTH   = WB_WIDTH,
    parameter int R_WIDTH = WB_R_WIDTH,
    parameter int DEPTH   = WB_DEPTH
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               pipe_valid_d,
    input  logic [R_WIDTH-1:0] pipe_addr_d,
    input  logic [WIDTH-1:0]   pipe_data_d,
    input  logic               mc_valid_d,
    output logic               mc_ready_q,
    input  logic [R_WIDTH-1:0] mc_addr_d,
    input  logic [WIDTH-1:0]   mc_data_d,
    output logic               write_q,
    output logic [R_WIDTH-1:0] write_addr_q,
    output logic [WIDTH-1:0]   write_data_q,
    input  logic [R_WIDTH-1:0] query_addr_d,
    output logic               pending_hit_q,
    output logic [WIDTH-1:0]   pending_data_q
);

    localparam int EW = R_WIDTH + WIDTH;
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 1);

    logic [CW-1:0]            q_count;
    logic [DEPTH-1:0]         q_valid;
    logic [DEPTH-1:0][EW-1:0] q_entries;

    logic          pipe_ok, mc_ok;
    logic          pop, push_a, push_b;
    logic [EW-1:0] data_a, data_b;
    wb_src_e       src;

    // One slot is always kept free for the pipeline, which cannot stall.
    assign mc_ready_q = q_count < READY_MAX;
    assign pipe_ok    = pipe_valid_d && pipe_addr_d != '0;
    assign mc_ok      = mc_valid_d && mc_ready_q && mc_addr_d != '0;

    // Oldest pending element goes to the output; the rest queue up behind.
    always_comb begin
        src    = SRC_NONE;
        pop    = 1'b0;
        push_a = 1'b0;
        push_b = 1'b0;
        data_a = {pipe_addr_d, pipe_data_d};
        data_b = {mc_addr_d, mc_data_d};
        if (q_count != '0) begin
            src    = SRC_QUEUE;
            pop    = 1'b1;
            push_a = pipe_ok;
            push_b = mc_ok;
        end else if (pipe_ok) begin
            src    = SRC_PIPE;
            push_a = mc_ok;
            data_a = {mc_addr_d, mc_data_d};
        end else if (mc_ok) begin
            src = SRC_MC;
        end
    end

    wb_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .pop     (pop),
        .push_a  (push_a),
        .data_a  (data_a),
        .push_b  (push_b),
        .data_b  (data_b),
        .count   (q_count),
        .valid   (q_valid),
        .entries (q_entries)
    );

    // Registered regfile write port; addr/data hold when idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            write_q      <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            write_q <= src != SRC_NONE;
            case (src)
                SRC_QUEUE: {write_addr_q, write_data_q} <= q_entries[0];
                SRC_PIPE:  {write_addr_q, write_data_q} <= {pipe_addr_d, pipe_data_d};
                SRC_MC:    {write_addr_q, write_data_q} <= {mc_addr_d, mc_data_d};
                default:   ;
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    // Youngest match wins: output register is oldest, then queue in order.
    always_comb begin
        pending_hit_q  = 1'b0;
        pending_data_q = '0;
        if (query_addr_d != '0) begin
            if (write_q && write_addr_q == query_addr_d) begin
                pending_hit_q  = 1'b1;
                pending_data_q = write_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (q_valid[i] && q_entries[i][EW-1 -: R_WIDTH] == query_addr_d) begin
                    pending_hit_q  = 1'b1;
                    pending_data_q = q_entries[i][WIDTH-1:0];
                end
            end
        end
    end
`else
    // No forwarding: decode relies on its scoreboard.
    logic unused_bypass;
    assign unused_bypass  = ^{query_addr_d, q_valid, q_entries};
    assign pending_hit_q  = 1'b0;
    assign pending_data_q = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        pipe_valid_d, mc_valid_d;
    logic [4:0]  pipe_addr_d, mc_addr_d, query_addr_d;
    logic [31:0] pipe_data_d, mc_data_d;
    logic        mc_ready_q, write_q, pending_hit_q;
    logic [4:0]  write_addr_q;
    logic [31:0] write_data_q, pending_data_q;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(.WIDTH(32), .R_WIDTH(5), .DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .pipe_valid_d   (pipe_valid_d),
        .pipe_addr_d    (pipe_addr_d),
        .pipe_data_d    (pipe_data_d),
        .mc_valid_d     (mc_valid_d),
        .mc_ready_q     (mc_ready_q),
        .mc_addr_d      (mc_addr_d),
        .mc_data_d      (mc_data_d),
        .write_q        (write_q),
        .write_addr_q   (write_addr_q),
        .write_data_q   (write_data_q),
        .query_addr_d   (query_addr_d),
        .pending_hit_q  (pending_hit_q),
        .pending_data_q (pending_data_q)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    // Reference model: writes not yet committed, in age order.
    ent_t mq[$];
    logic ov;
    ent_t oreg;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock of stimulus: check combinational outputs, then the write port.
    task automatic step(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic [4:0] qa);
        ent_t        pend[$];
        ent_t        e;
        logic        rdy, hit;
        logic [31:0] hd;
        pipe_valid_d = pv; pipe_addr_d = pa; pipe_data_d = pd;
        mc_valid_d   = mv; mc_addr_d   = ma; mc_data_d   = md;
        query_addr_d = qa;
        #1;
        rdy = mq.size() < DEPTH - 1;
        chk("mc_ready", {31'b0, mc_ready_q}, {31'b0, rdy});
        hit = 1'b0; hd = '0;
`ifdef WB_BYPASS_EN
        if (qa != 0) begin
            if (ov && oreg.a == qa) begin hit = 1'b1; hd = oreg.d; end
            foreach (mq[i]) if (mq[i].a == qa) begin hit = 1'b1; hd = mq[i].d; end
        end
`endif
        chk("pending_hit", {31'b0, pending_hit_q}, {31'b0, hit});
        chk("pending_data", pending_data_q, hd);
        pend = mq;
        if (pv && pa != 0) begin e.a = pa; e.d = pd; pend.push_back(e); end
        if (mv && rdy && ma != 0) begin e.a = ma; e.d = md; pend.push_back(e); end
        @(posedge clk_i); #1;
        if (pend.size() > 0) begin ov = 1'b1; oreg = pend.pop_front(); end
        else ov = 1'b0;
        mq = pend;
        chk("write_q", {31'b0, write_q}, {31'b0, ov});
        if (ov) begin
            chk("write_addr", {27'b0, write_addr_q}, {27'b0, oreg.a});
            chk("write_data", write_data_q, oreg.d);
        end
    endtask

    task automatic idle(input logic [4:0] qa);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa);
    endtask

    initial begin
        rst_n_i = 1'b0;
        pipe_valid_d = 0; pipe_addr_d = 0; pipe_data_d = 0;
        mc_valid_d = 0; mc_addr_d = 0; mc_data_d = 0; query_addr_d = 0;
        ov = 1'b0; oreg.a = '0; oreg.d = '0;
        #2;
        chk("rst_write_q", {31'b0, write_q}, 32'd0);
        chk("rst_write_addr", {27'b0, write_addr_q}, 32'd0);
        chk("rst_write_data", write_data_q, 32'd0);
        chk("rst_mc_ready", {31'b0, mc_ready_q}, 32'd1);
        chk("rst_hit", {31'b0, pending_hit_q}, 32'd0);
        chk("rst_pdata", pending_data_q, 32'd0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;

        // Single pipe write on an empty queue, then idle.
        step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0);
        idle(5'd0);
        idle(5'd0);

        // Same-cycle pipe and mc: pipe first, mc visible to bypass meanwhile.
        step(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB, 5'd0);
        idle(5'd7);
        idle(5'd7);

        // Both sources saturated: queue fills until mc is held off.
        for (int i = 0; i < 6; i++)
            step(1'b1, 5'(1 + 2*i), 32'h100 + i, 1'b1, 5'(2 + 2*i), 32'h200 + i, 5'(2 + 2*i));
        for (int i = 0; i < 5; i++) idle(5'd12);

        // r0 writes are discarded and never hit.
        step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd0);
        idle(5'd0);

        // Same address in both requests: both queued, youngest forwarded.
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd0);
        step(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 5'd9);
        idle(5'd9);
        idle(5'd9);
        idle(5'd9);

        // Reset with two entries queued.
        step(1'b1, 5'd1, 32'h31, 1'b1, 5'd2, 32'h32, 5'd0);
        step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h34, 5'd3);
        pipe_valid_d = 0; mc_valid_d = 0; query_addr_d = 5'd3;
        #2 rst_n_i = 1'b0;
        #1;
        chk("midrst_write_q", {31'b0, write_q}, 32'd0);
        chk("midrst_mc_ready", {31'b0, mc_ready_q}, 32'd1);
        chk("midrst_hit", {31'b0, pending_hit_q}, 32'd0);
        mq.delete(); ov = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        idle(5'd3);
        idle(5'd4);

        // Random traffic, including r0 and address collisions.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] pa, ma, qa;
            pa = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31));
            ma = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31));
            qa = 5'($urandom_range(0, 2) == 0 ? pa : $urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), pa, $urandom,
                 1'($urandom_range(0, 3) != 0), ma, $urandom, qa);
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(5'($urandom_range(0, 31)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Runaway guard.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and buffer for the register-file write port. Merges results from the in-order pipeline writeback stage and the multicycle unit (loads and mult/div) onto the single regfile write port. Pending writes are held in a small ordered queue, and writes to r0 are dropped. It provides a bypass lookup so decode can forward values not yet committed to the register file.

## Interface
Parameters:
- WIDTH, 32, datapath width (matches `WIDTH)
- R_WIDTH, 5, register address width (matches `R_WIDTH)
- DEPTH, 4, pending-queue entries, minimum 2

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- pipe_valid_d  in  1  pipeline writeback request; cannot be back-pressured
- pipe_addr_d  in  R_WIDTH  pipeline destination register
- pipe_data_d  in  WIDTH  pipeline result
- mc_valid_d  in  1  multicycle request
- mc_ready_q  out  1  multicycle request accepted this cycle when high with mc_valid_d
- mc_addr_d  in  R_WIDTH  multicycle destination register
- mc_data_d  in  WIDTH  multicycle result
- write_q  out  1  regfile write enable (registered)
- write_addr_q  out  R_WIDTH  regfile write address (registered)
- write_data_q  out  WIDTH  regfile write data (registered)
- query_addr_d  in  R_WIDTH  bypass lookup address
- pending_hit_q  out  1  query matches a pending write (combinational)
- pending_data_q  out  WIDTH  data of youngest matching pending write (combinational)

## Operation
- Pending set: queue entries in age order, then this cycle's accepted pipe request, then the accepted mc request. Requests with addr 0 are accepted and discarded.
- Each cycle, the oldest element of the pending set loads the output register: write_q=1 with its addr/data. The remainder stays in or enters the queue. If the set is empty, write_q=0.
- The regfile never stalls, so exactly one element drains per non-empty cycle.
- mc_ready_q = (count < DEPTH-1), where count is the registered queue occupancy. This reserves one slot for the pipeline, so the queue never overflows and pipe requests are never lost.
- Same-cycle pipe and mc requests: pipe is ordered ahead of mc.
- Same non-zero address in both requests in one cycle: both writes are performed, mc last, so mc wins.
- Bypass searches the queue entries plus the output register while write_q=1. pending_data_q is from the youngest match. Query addr 0 never hits.

## Timing
- Reset values: write_q=0, write_addr_q=0, write_data_q=0, count=0, so mc_ready_q=1. pending_hit_q=0 and pending_data_q=0 with an empty queue.
- Latency with an empty queue: request in cycle n gives write_q=1 in cycle n+1, and the regfile commits at the end of n+1.
- With k queued entries: a new request reaches the output k cycles later than in the empty case.
- Count changes by at most +1 per cycle (two pushes, one pop); count ≤ DEPTH-1 always.
- Reset asserted mid-operation: queue and output register cleared immediately; pending writes are lost, by design.

## Configuration
- WB_BYPASS_EN defined: query_addr_d, pending_hit_q and pending_data_q are functional as above.
- WB_BYPASS_EN undefined: the ports remain; pending_hit_q and pending_data_q are tied to 0 and the comparators are not built. Decode must then stall on a scoreboard instead.

## Structure
- `WIDTH, `R_WIDTH and `REGSIZE come from the shared CPU defines header. No new constants are added there.
- A local entry struct/concat {addr, data} is acceptable inside the block.
- One sub-module: wb_fifo, a DEPTH-entry ordered queue.
  - Supports 0–2 pushes and 0–1 pop per cycle.
  - Exposes all entries plus valid bits for the bypass search.
- Arbitration, output register and bypass mux are in wb_arbiter.

## Test plan
- Reset mid-stream with 2 entries queued -> write_q=0 and mc_ready_q=1 immediately. No further writes until new requests arrive.
- Empty queue, pipe addr 5 data 0x1234 in cycle n -> cycle n+1: write_q=1, addr 5, data 0x1234. Cycle n+2: write_q=0.
- Same cycle, pipe addr 3/0xA and mc addr 7/0xB -> addr 3 in n+1, addr 7 in n+2, pending_hit_q=1 for query 7 during n+1.
- DEPTH=4, both sources valid with distinct addrs for 6 cycles -> mc_ready_q falls when count=3. Every accepted request is written exactly once, in order, with no pipe loss.
- Pipe addr 0 data 0xFFFF, queue empty -> write_q stays 0, pending_hit_q=0 for query 0.
- Queue holds addr 9/0x1 then addr 9/0x2 -> query 9 returns hit=1, data 0x2. Without WB_BYPASS_EN -> hit=0, data=0.
